vjtag_cmd_parser: RTL and testbench
===================================

Name: vjtag_cmd_parser

Overview:
- Downstream consumer of the virtual-JTAG serial receiver.
- Receives the byte stream in the CLOCK_50 domain through a valid/ready handshake and assembles the bytes into a line buffer.
- On CR or LF it decodes a one-line ASCII command, updates the LED register and queues an ASCII response on a tx byte stream back toward the JTAG side.

Parameters:
- MAX_LEN, 16, line buffer depth in bytes; must be >= 4.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts tx_data.
- led  out  8  LED register.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset values: led=0, tx_valid=0, tx_data=0, rx_ready=0 during reset, busy=0, len=0, ovf=0, state=RECV. Reset asserted mid-line or mid-response aborts immediately; no partial response is sent after release.
- States: RECV, EXEC, RESP.
- RECV:
  - rx_ready=1.
  - A byte is accepted when rx_valid & rx_ready.
  - CR (0x0D) or LF (0x0A) with len==0: ignored, so CRLF pairs and blank lines produce no response.
  - CR or LF with len>0: go to EXEC.
  - Any other byte with len<MAX_LEN: stored at buf[len]; len++.
  - Any other byte with len==MAX_LEN: dropped; ovf set.
- EXEC (exactly 1 cycle, rx_ready=0): decode buf[0..len-1] and load the response buffer.
  - ovf set: response "ER\r\n".
  - 'L' or 'l', len==3, buf[1..2] valid hex (0-9, A-F, a-f): led <= value; response "OK\r\n".
  - 'T' or 't', len==1: led[0] toggles; response "OK\r\n".
  - '?', len==1: response "L" + two uppercase hex digits of the current led + "\r\n" (5 bytes).
  - Anything else: response "ER\r\n"; led unchanged.
  - led updates in the EXEC cycle and is visible the next cycle.
- RESP (rx_ready=0):
  - tx_valid=1; tx_data = resp[idx].
  - tx_data and tx_valid hold stable until tx_ready.
  - On a handshake, idx++.
  - After the last byte's handshake: len=0, ovf=0, idx=0, state=RECV in the same edge.
- Latency: terminator accepted at edge N, EXEC at N+1, tx_valid high from N+2.
- rx bytes presented while rx_ready=0 are not consumed; upstream holds them.
- busy = (state != RECV).

Optional Feature:
- Macro VJTAG_PARSER_ECHO_EN.
- Defined:
  - In RECV, each accepted non-terminator byte, stored or dropped, is loaded into an echo register.
  - The cycle after acceptance: tx_valid=1 with that byte, rx_ready=0 until the tx handshake completes.
  - A terminator accepted with len>0 emits no echo; EXEC follows directly.
  - The response is unchanged.
- Undefined: tx is used only in RESP; no echo register exists.

Decomposition:
- Shared package vjtag_pkg:
  - ASCII constants: CR, LF, 'O', 'K', 'E', 'R', 'L'.
  - State enum {RECV, EXEC, RESP}.
  - Function hex2nib returning {valid, nibble}.
  - Function nib2hex (uppercase).
  - RESP_MAX=5.
- One sub-module, vjtag_resp_tx: holds the 5-byte response buffer and length, serializes it with the valid/ready handshake, and pulses done on the last byte. The parser FSM stays in the top module.

Test Plan:
- Send "L5A\r", tx_ready=1 → led=0x5A; tx sequence 'O','K',0x0D,0x0A; the following LF produces no second response.
- Send "?\n" after led=0x5A → tx "L5A\r\n" (0x4C,0x35,0x41,0x0D,0x0A).
- Send "T\r" twice from led=0x00 → led 0x01, then 0x00; each produces "OK\r\n".
- Send 20 'A' bytes then LF with MAX_LEN=16 → "ER\r\n"; led unchanged; the next "l0f\r" gives led=0x0F (ovf cleared).
- Hold tx_ready=0 for 10 cycles during RESP while rx_valid=1 → tx_data stable, rx_ready=0, no rx byte consumed; assert RESET_N=0 mid-response → tx_valid=0 and led=0 asynchronously.
- With VJTAG_PARSER_ECHO_EN: send "T\r" → tx 'T', then "OK\r\n"; rx_ready low between 'T' acceptance and its tx handshake.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared constants, state encoding and ASCII hex helpers for the virtual-JTAG
// command parser.
package vjtag_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_QM = 8'h3F;

  localparam int RESP_MAX = 5;

  // Response byte 0 sits in the least significant lane.
  localparam logic [RESP_MAX-1:0][7:0] RESP_OK = {8'h00, ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
  localparam logic [RESP_MAX-1:0][7:0] RESP_ER = {8'h00, ASCII_LF, ASCII_CR, ASCII_R, ASCII_E};

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

endpackage

// File: rtl/vjtag_resp_tx.sv
// Response serializer: latches up to RESP_MAX bytes on load_i and streams them
// out over a valid/ready port, pulsing done_o with the last byte's handshake.
module vjtag_resp_tx
  import vjtag_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [RESP_MAX-1:0][7:0] data_i,
  input  logic [2:0]               len_i,
  input  logic                     tx_ready_i,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  output logic                     done_o
);

  logic [RESP_MAX-1:0][7:0] bytes_q, bytes_d;
  logic [2:0]               len_q, len_d;
  logic [2:0]               idx_q, idx_d;
  logic                     active_q, active_d;
  logic                     last;

  assign last       = (idx_q == len_q - 3'd1);
  assign tx_valid_o = active_q;
  assign tx_data_o  = active_q ? bytes_q[idx_q] : 8'h00;
  assign done_o     = active_q & tx_ready_i & last;

  always_comb begin
    bytes_d  = bytes_q;
    len_d    = len_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load_i) begin
      bytes_d  = data_i;
      len_d    = len_i;
      idx_d    = 3'd0;
      active_d = 1'b1;
    end else if (active_q && tx_ready_i) begin
      if (last) begin
        idx_d    = 3'd0;
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bytes_q  <= '0;
      len_q    <= 3'd0;
      idx_q    <= 3'd0;
      active_q <= 1'b0;
    end else begin
      bytes_q  <= bytes_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/vjtag_cmd_parser.sv
// Line-oriented ASCII command parser (L<hh>, T, ?) driving an LED register and
// answering on a tx byte stream. Optional echo of received bytes: VJTAG_PARSER_ECHO_EN.
module vjtag_cmd_parser
  import vjtag_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] led,
  output logic       busy,
  output state_e     dbg_state
);

  // Both byte streams: a byte moves on a rising edge where valid && ready are
  // both high; the sender holds data and valid stable until that edge.

  localparam int LENW = $clog2(MAX_LEN + 1);
  localparam int IDXW = $clog2(MAX_LEN);

  state_e                   state_q, state_d;
  logic [LENW-1:0]          len_q, len_d;
  logic                     ovf_q, ovf_d;
  logic [7:0]               led_q, led_d;
  logic [7:0]               line_q [MAX_LEN];
  logic                     line_we;

  logic                     rx_fire, is_term;
  logic [4:0]               n1, n2;
  logic                     is_l, is_t;

  logic                     resp_load, resp_valid, resp_done;
  logic [RESP_MAX-1:0][7:0] resp_data;
  logic [2:0]               resp_len;
  logic [7:0]               resp_byte;

  assign rx_fire   = rx_valid & rx_ready;
  assign is_term   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign n1        = hex2nib(line_q[1]);
  assign n2        = hex2nib(line_q[2]);
  assign is_l      = (line_q[0] | 8'h20) == (ASCII_L | 8'h20);
  assign is_t      = (line_q[0] | 8'h20) == (ASCII_T | 8'h20);
  assign led       = led_q;
  assign busy      = (state_q != RECV);
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    led_d     = led_q;
    line_we   = 1'b0;
    resp_load = 1'b0;
    resp_data = RESP_ER;
    resp_len  = 3'd4;
    case (state_q)
      RECV: begin
        if (rx_fire) begin
          if (is_term) begin
            // Empty terminators (second half of CRLF, blank lines) are swallowed.
            if (len_q != '0) state_d = EXEC;
          end else if (len_q < LENW'(MAX_LEN)) begin
            line_we = 1'b1;
            len_d   = len_q + LENW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      EXEC: begin
        resp_load = 1'b1;
        state_d   = RESP;
        if (!ovf_q) begin
          if (is_l && len_q == LENW'(3) && n1[4] && n2[4]) begin
            led_d     = {n1[3:0], n2[3:0]};
            resp_data = RESP_OK;
          end else if (is_t && len_q == LENW'(1)) begin
            led_d     = led_q ^ 8'h01;
            resp_data = RESP_OK;
          end else if (line_q[0] == ASCII_QM && len_q == LENW'(1)) begin
            resp_data = {ASCII_LF, ASCII_CR, nib2hex(led_q[3:0]), nib2hex(led_q[7:4]), ASCII_L};
            resp_len  = 3'd5;
          end
        end
      end
      RESP: begin
        if (resp_done) begin
          state_d = RECV;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= RECV;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_LEN; i++) line_q[i] <= 8'h00;
    end else if (line_we) begin
      line_q[len_q[IDXW-1:0]] <= rx_data;
    end
  end

  vjtag_resp_tx u_resp_tx (
    .clk_i      (CLOCK_50),
    .rst_ni     (RESET_N),
    .load_i     (resp_load),
    .data_i     (resp_data),
    .len_i      (resp_len),
    .tx_ready_i (tx_ready),
    .tx_valid_o (resp_valid),
    .tx_data_o  (resp_byte),
    .done_o     (resp_done)
  );

`ifdef VJTAG_PARSER_ECHO_EN
  logic [7:0] echo_q, echo_d;
  logic       echo_valid_q, echo_valid_d;

  // Echo and response never overlap: echoes only happen in RECV.
  always_comb begin
    echo_d       = echo_q;
    echo_valid_d = echo_valid_q;
    if (echo_valid_q && tx_ready) echo_valid_d = 1'b0;
    if (rx_fire && !is_term) begin
      echo_d       = rx_data;
      echo_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      echo_q       <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      echo_q       <= echo_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  assign rx_ready = RESET_N && (state_q == RECV) && !echo_valid_q;
  assign tx_valid = echo_valid_q | resp_valid;
  assign tx_data  = echo_valid_q ? echo_q : resp_byte;
`else
  assign rx_ready = RESET_N && (state_q == RECV);
  assign tx_valid = resp_valid;
  assign tx_data  = resp_byte;
`endif

endmodule

// File: tb/tb_vjtag_cmd_parser.sv
// Bench for vjtag_cmd_parser: reset checks, table of command lines, timing and
// abort sequences, then random lines against a line-level reference model.
module tb_vjtag_cmd_parser;
  import vjtag_pkg::state_e;
  import vjtag_pkg::RECV;
  import vjtag_pkg::EXEC;

  localparam int MAX_LEN = 16;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] led;
  logic       busy;
  state_e     dbg_state;

  vjtag_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .led       (led),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         rnd_rdy   = 1'b0;
  bit         use_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A handshake seen here completes on the following rising edge.
  always @(negedge CLOCK_50) begin
    if (RESET_N && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- reference model (line level) ----------------
  logic [7:0] mline[$];
  bit         movf = 1'b0;
  logic [7:0] mled = 8'h00;

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  task automatic push_resp(input string body);
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_query(input logic [7:0] v);
    string hx;
    hx = "0123456789ABCDEF";
    exp_q.push_back("L");
    exp_q.push_back(hx[v / 16]);
    exp_q.push_back(hx[v % 16]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic model_exec();
    int n;
    n = mline.size();
    if (movf) push_resp("ER");
    else if (n == 3 && (mline[0] == "L" || mline[0] == "l") && is_hex(mline[1]) && is_hex(mline[2])) begin
      mled = 8'(hex_val(mline[1]) * 16 + hex_val(mline[2]));
      push_resp("OK");
    end else if (n == 1 && (mline[0] == "T" || mline[0] == "t")) begin
      mled = {mled[7:1], ~mled[0]};
      push_resp("OK");
    end else if (n == 1 && mline[0] == "?") push_query(mled);
    else push_resp("ER");
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      if (mline.size() > 0) begin
        model_exec();
        mline.delete();
        movf = 1'b0;
      end
    end else if (mline.size() < MAX_LEN) mline.push_back(b);
    else movf = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && n < 200) begin
      acc = rx_ready;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL rx_accept: byte %02h not accepted after %0d cycles", b, n);
    end else begin
`ifdef VJTAG_PARSER_ECHO_EN
      if (b != 8'h0D && b != 8'h0A) exp_q.push_back(b);
`endif
      if (use_model) model_byte(b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || tx_valid) && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, {31'h0, n < 1000}, 32'h1);
    if (n >= 1000) exp_q.delete();
    repeat (4) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      cmd;
    logic [7:0] term;
    logic [7:0] led;
    string      resp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string c, input logic [7:0] t, input logic [7:0] l, input string r);
    vec_t v;
    v.cmd  = c;
    v.term = t;
    v.led  = l;
    v.resp = r;
    vq.push_back(v);
  endtask

  logic [7:0] cur_led;

  initial begin
    logic [7:0] line[$];
    string      pool;
    int         k;

    // reset state
    #5;
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, RECV});
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick();
    check("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);

    // table-driven lines
    add_vec("L5A", 8'h0D, 8'h5A, "OK");
    add_vec("", 8'h0A, 8'h5A, "");
    add_vec("?", 8'h0A, 8'h5A, "L5A");
    add_vec("l00", 8'h0D, 8'h00, "OK");
    add_vec("T", 8'h0D, 8'h01, "OK");
    add_vec("t", 8'h0D, 8'h00, "OK");
    add_vec("AAAAAAAAAAAAAAAAAAAA", 8'h0A, 8'h00, "ER");
    add_vec("l0f", 8'h0D, 8'h0F, "OK");
    add_vec("LG1", 8'h0D, 8'h0F, "ER");
    add_vec("L1", 8'h0D, 8'h0F, "ER");
    add_vec("T1", 8'h0D, 8'h0F, "ER");
    add_vec("?", 8'h0D, 8'h0F, "L0F");
    add_vec("XXXXXXXXXXXXXXXX", 8'h0D, 8'h0F, "ER");
    add_vec("LfF", 8'h0D, 8'hFF, "OK");
    add_vec("?", 8'h0A, 8'hFF, "LFF");
    add_vec("Lc3", 8'h0A, 8'hC3, "OK");
    for (int i = 0; i < vq.size(); i++) begin
      send_str(vq[i].cmd);
      send_byte(vq[i].term);
      if (vq[i].resp.len() > 0) push_resp(vq[i].resp);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vq[i].led});
    end
    cur_led = 8'hC3;

    // latency: terminator at edge N, EXEC until N+1, tx_valid from then on
    send_byte("T");
    wait_idle("lat_pre");
    send_byte(8'h0D);
    push_resp("OK");
    check("lat_exec_state", {30'h0, dbg_state}, {30'h0, EXEC});
    check("lat_exec_busy", {31'h0, busy}, 32'h1);
    check("lat_exec_tx_valid", {31'h0, tx_valid}, 32'h0);
    tick();
    check("lat_resp_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("lat_resp_tx_data", {24'h0, tx_data}, 32'h4F);
    wait_idle("lat");
    cur_led = cur_led ^ 8'h01;
    check("lat_led", {24'h0, led}, {24'h0, cur_led});

`ifdef VJTAG_PARSER_ECHO_EN
    // echo holds off rx until its own handshake
    tx_ready = 1'b0;
    send_byte("T");
    for (int i = 0; i < 3; i++) begin
      check("echo_rx_ready", {31'h0, rx_ready}, 32'h0);
      check("echo_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("echo_tx_data", {24'h0, tx_data}, 32'h54);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("echo_pre");
    check("echo_rx_ready_after", {31'h0, rx_ready}, 32'h1);
    send_byte(8'h0D);
    push_resp("OK");
    wait_idle("echo");
    cur_led = cur_led ^ 8'h01;
    check("echo_led", {24'h0, led}, {24'h0, cur_led});
`endif

    // back-pressure during RESP with an rx byte waiting
    send_byte("?");
    wait_idle("hold_pre");
    tx_ready = 1'b0;
    send_byte(8'h0D);
    push_query(cur_led);
    for (int n = 0; n < 20 && !tx_valid; n++) tick();
    rx_data  = "X";
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("hold_tx_data", {24'h0, tx_data}, 32'h4C);
      check("hold_rx_ready", {31'h0, rx_ready}, 32'h0);
      tick();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle("hold");
    send_byte(8'h0D);
    wait_idle("hold_post");

    // randomized lines against the model
    mled      = cur_led;
    mline.delete();
    movf      = 1'b0;
    use_model = 1'b1;
    rnd_rdy   = 1'b1;
    pool      = "0123456789abcdefABCDEFgG:/";
    for (int r = 0; r < 40; r++) begin
      line.delete();
      k = $urandom_range(0, 5);
      case (k)
        0: begin
          line.push_back(($urandom_range(0, 1) != 0) ? 8'h4C : 8'h6C);
          line.push_back(pool[$urandom_range(0, pool.len() - 1)]);
          line.push_back(pool[$urandom_range(0, pool.len() - 1)]);
        end
        1: line.push_back(($urandom_range(0, 1) != 0) ? 8'h54 : 8'h74);
        2: line.push_back(8'h3F);
        3: begin
          int len;
          len = $urandom_range(1, 20);
          for (int j = 0; j < len; j++) line.push_back(8'($urandom_range(32, 126)));
        end
        4: ;
        default: begin
          line.push_back(($urandom_range(0, 1) != 0) ? 8'h54 : 8'h3F);
          line.push_back(8'($urandom_range(32, 126)));
        end
      endcase
      line.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 2) == 0) line.push_back(8'h0A);
      foreach (line[j]) send_byte(line[j]);
      wait_idle($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_led", r), {24'h0, led}, {24'h0, mled});
    end
    rnd_rdy  = 1'b0;
    tx_ready = 1'b1;
    repeat (2) tick();

    // reset in the middle of a response
    send_byte("?");
    wait_idle("abort_pre");
    tx_ready = 1'b0;
    send_byte(8'h0D);
    for (int n = 0; n < 20 && !tx_valid; n++) tick();
    check("abort_tx_valid_pre", {31'h0, tx_valid}, 32'h1);
    RESET_N = 1'b0;
    #1;
    check("abort_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("abort_led", {24'h0, led}, 32'h0);
    check("abort_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    mline.delete();
    movf     = 1'b0;
    mled     = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick();
    repeat (10) tick();
    check("abort_no_resume", {31'h0, tx_valid}, 32'h0);
    send_byte("?");
    send_byte(8'h0A);
    wait_idle("abort_post");
    check("abort_post_led", {24'h0, led}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
